aes_round_sched: RTL and testbench

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_rnd_cnt.sv | 26 ++
 rtl/aes_round_sched.sv | 113 +++++++++++
 tb/tb_aes_round_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES sequencing definitions: block width, round count and the
// round-scheduler state encoding.
package aes_pkg;

  localparam int AES_NUM_RNDS = 10;
  localparam int AES_BLK_W    = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/aes_rnd_cnt.sv
// Round counter for the AES scheduler: loads 1 on block start, steps once per
// round and returns to 0 after the last round, so it never exceeds NUM_RNDS.
module aes_rnd_cnt #(
  parameter int NUM_RNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       adv,
  output logic [3:0] cnt,
  output logic       last
);

  assign last = (cnt == 4'(NUM_RNDS));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (start) begin
      cnt <= 4'd1;
    end else if (adv) begin
      cnt <= last ? 4'd0 : cnt + 4'd1;
    end
  end

endmodule

// File: rtl/aes_round_sched.sv
// AES round scheduler: sequences one block through NUM_RNDS rounds of an
// external datapath. Optional block counter enabled by AES_SCHED_PERF_EN.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// ROUND | one round per cycle, dp_rnd = current round
// DONE  | ciphertext held on out_data until out_ready
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NUM_RNDS = AES_NUM_RNDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  input  logic [AES_BLK_W-1:0] in_key,
  output logic [3:0]           dp_rnd,
  output logic [AES_BLK_W-1:0] dp_state,
  output logic [AES_BLK_W-1:0] dp_key,
  input  logic [AES_BLK_W-1:0] dp_state_nxt,
  input  logic [AES_BLK_W-1:0] dp_key_nxt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy
`ifdef AES_SCHED_PERF_EN
  ,
  output logic [31:0]          blk_cnt
`endif
);

  sched_state_t state;
  logic         accept;
  logic         in_round;
  logic         last_rnd;
  logic [3:0]   rnd_cnt;

  assign accept   = (state == IDLE) && in_valid && in_ready;
  assign in_round = (state == ROUND);

  aes_rnd_cnt #(
    .NUM_RNDS (NUM_RNDS)
  ) u_rnd_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .adv   (in_round),
    .cnt   (rnd_cnt),
    .last  (last_rnd)
  );

  // Counter is 0 outside ROUND, so it can drive the datapath directly.
  assign dp_rnd   = rnd_cnt;
  assign out_data = dp_state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dp_state  <= '0;
      dp_key    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dp_state <= in_data ^ in_key;
            dp_key   <= in_key;
            state    <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          dp_state <= dp_state_nxt;
          dp_key   <= dp_key_nxt;
          if (last_rnd) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_cnt <= 32'd0;
    end else if ((state == DONE) && out_ready) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched with a behavioural AES-128 round
// model standing in for the external datapath and key expansion.
module tb_aes_round_sched;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic [3:0]   dp_rnd;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic [127:0] dp_state_nxt;
  logic [127:0] dp_key_nxt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_SCHED_PERF_EN
  logic [31:0]  blk_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_hs  = 0;
  logic [127:0] last_out;
  logic         out_valid_prev = 1'b0;
  logic [127:0] exp_q[$];
  int           acc_q[$];
  int           acc_hist[$];
  logic [7:0]   sbox_t [256];

  aes_round_sched dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_key       (in_key),
    .dp_rnd       (dp_rnd),
    .dp_state     (dp_state),
    .dp_key       (dp_key),
    .dp_state_nxt (dp_state_nxt),
    .dp_key_nxt   (dp_key_nxt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
`ifdef AES_SCHED_PERF_EN
    ,
    .blk_cnt      (blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, rw, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    rw = {w3[23:0], w3[31:24]};
    t  = {sbox_t[rw[31:24]], sbox_t[rw[23:16]], sbox_t[rw[15:8]], sbox_t[rw[7:0]]};
    t  = t ^ {rcon(r), 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] st, input logic [127:0] rk,
                                           input logic fin);
    logic [7:0] b [16];
    logic [7:0] s [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = st[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = sbox_t[b[4*((c+r)%4)+r]];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
        s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o ^ rk;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] st = pt ^ key;
    logic [127:0] k  = key;
    for (int r = 1; r <= 10; r++) begin
      k  = key_step(k, 4'(r));
      st = aes_rnd(st, k, r == 10);
    end
    return st;
  endfunction

  // External round datapath and key expansion model.
  always_comb begin
    dp_key_nxt   = key_step(dp_key, dp_rnd);
    dp_state_nxt = aes_rnd(dp_state, dp_key_nxt, dp_rnd == 4'd10);
  end

  // Scoreboard monitor; inputs change at posedge+1, so negedge values are
  // exactly what the next rising edge samples.
  always @(negedge clk) begin
    cyc++;
    if (rst && in_valid && in_ready) begin
      exp_q.push_back(aes_ref(in_data, in_key));
      acc_q.push_back(cyc);
      acc_hist.push_back(cyc);
    end
    if (out_valid && !out_valid_prev) begin
      total++;
      if (acc_q.size() == 0) begin
        bad++;
        $display("FAIL out_valid_unexpected: out_valid=1 required no pending block");
      end else if (cyc - acc_q[0] != 11) begin
        bad++;
        $display("FAIL latency: got %0d cycles required 11", cyc - acc_q[0]);
      end
    end
    if (rst && out_valid && out_ready) begin
      total++;
      n_hs++;
      last_out = out_data;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: out_data=%h with no expected block", out_data);
      end else begin
        if (out_data !== exp_q[0]) begin
          bad++;
          $display("FAIL scoreboard_data: got %h required %h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
    end
    out_valid_prev = out_valid;
  end

  task automatic send_block(input logic [127:0] pt, input logic [127:0] key);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = pt; in_key = key;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        total++; bad++;
        $display("FAIL accept_timeout: in_ready=0 required 1 within 100 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (n_hs < target) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL handshake_timeout: handshakes=%0d required %0d", n_hs, target);
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 5;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (dp_rnd !== 4'd0) begin bad++; $display("FAIL rst_dp_rnd: got %0d required 0", dp_rnd); end
    if (dp_state !== 128'h0) begin bad++; $display("FAIL rst_dp_state: got %h required 0", dp_state); end
  endtask

  task automatic test_vector(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] ct, input string name);
    int base = n_hs;
    out_ready = 1'b1;
    send_block(pt, key);
    wait_hs(base + 1);
    total++;
    if (last_out !== ct) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, last_out, ct);
    end
  endtask

  task automatic test_stall();
    logic [127:0] held;
    int n = 0;
    int base = n_hs;
    out_ready = 1'b0;
    send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!out_valid) begin bad++; $display("FAIL stall_done_timeout: out_valid=0 required 1"); end
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b required 1", out_valid); end
      if (out_data !== held) begin bad++; $display("FAIL stall_data: got %h required %h", out_data, held); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total += 3;
    if (n_hs !== base + 1) begin bad++; $display("FAIL stall_hs: got %0d required %0d", n_hs, base + 1); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_idle: in_ready=%b required 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release_valid: got %b required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int base;
    out_ready = 1'b1;
    send_block(128'h0123456789abcdef0123456789abcdef, 128'hfedcba9876543210fedcba9876543210);
    while (dp_rnd != 4'd5 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (dp_rnd !== 4'd5) begin bad++; $display("FAIL midrst_round: dp_rnd=%0d required 5", dp_rnd); end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    total += 5;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b required 1", in_ready); end
    if (dp_state !== 128'h0) begin bad++; $display("FAIL midrst_dp_state: got %h required 0", dp_state); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
    if (dp_rnd !== 4'd0) begin bad++; $display("FAIL midrst_dp_rnd: got %0d required 0", dp_rnd); end
    base = n_hs;
    send_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    wait_hs(base + 1);
    total++;
    if (last_out !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      bad++;
      $display("FAIL midrst_recover: got %h required 69c4e0d86a7b0430d8cdb78070b4c55a", last_out);
    end
  endtask

  task automatic test_back_to_back();
    int base = n_hs;
    int n = 0;
    acc_hist.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    while (acc_hist.size() < 3 && n < 100) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    total++;
    if (acc_hist.size() < 3) begin
      bad++;
      $display("FAIL b2b_accepts: got %0d required 3", acc_hist.size());
    end else begin
      total += 2;
      if (acc_hist[1] - acc_hist[0] != 12) begin
        bad++; $display("FAIL b2b_spacing1: got %0d required 12", acc_hist[1] - acc_hist[0]);
      end
      if (acc_hist[2] - acc_hist[1] != 12) begin
        bad++; $display("FAIL b2b_spacing2: got %0d required 12", acc_hist[2] - acc_hist[1]);
      end
    end
    wait_hs(base + 3);
  endtask

`ifdef AES_SCHED_PERF_EN
  task automatic test_perf();
    int base;
    apply_reset();
    @(negedge clk);
    total++;
    if (blk_cnt !== 32'd0) begin bad++; $display("FAIL perf_reset: got %0d required 0", blk_cnt); end
    base = n_hs;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    wait_hs(base + 3);
    @(negedge clk);
    total++;
    if (blk_cnt !== 32'd3) begin bad++; $display("FAIL perf_count: got %0d required 3", blk_cnt); end
    @(posedge clk); #1;
    force dut.blk_cnt = 32'hffff_ffff;
    @(negedge clk);
    release dut.blk_cnt;
    base = n_hs;
    send_block(128'h0, 128'h0);
    wait_hs(base + 1);
    @(negedge clk);
    total++;
    if (blk_cnt !== 32'd0) begin bad++; $display("FAIL perf_wrap: got %h required 0", blk_cnt); end
  endtask
`endif

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_vector(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips_c1");
    test_vector(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "all_zero");
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef AES_SCHED_PERF_EN
    test_perf();
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
